// File: rtl/fir_mac_sched_if.sv
// Bundle of the handshake and multiplier signals around the FIR MAC sequencer.
// The master side is the environment: sample source, downstream consumer,
// coefficient writer and the combinational multiplier. The slave side is the
// sequencer itself.
interface fir_mac_sched_if #(
  parameter int TAPS = 4,
  parameter int DW   = 8,
  parameter int ACCW = 18
);
  localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;

  // Coefficient bank write port
  logic                   coef_we;
  logic [TW-1:0]          coef_addr;
  logic signed [DW-1:0]   coef_data;
  logic                   coef_ack;

  // Sample input handshake
  logic                   in_valid;
  logic                   in_ready;
  logic signed [DW-1:0]   in_sample;

  // Shared multiplier operands and product
  logic signed [DW-1:0]   mult_a;
  logic signed [DW-1:0]   mult_b;
  logic signed [2*DW-1:0] mult_p;

  // Filter output handshake
  logic                   out_valid;
  logic                   out_ready;
  logic signed [ACCW-1:0] out_data;

  modport master (
    output coef_we, coef_addr, coef_data,
    output in_valid, in_sample,
    output mult_p,
    output out_ready,
    input  coef_ack, in_ready, mult_a, mult_b, out_valid, out_data
  );

  modport slave (
    input  coef_we, coef_addr, coef_data,
    input  in_valid, in_sample,
    input  mult_p,
    input  out_ready,
    output coef_ack, in_ready, mult_a, mult_b, out_valid, out_data
  );
endinterface

// File: rtl/fir_mac_sched.sv
// FIR MAC sequencer: owns the coefficient bank and sample delay line, feeds one
// (coefficient, sample) pair per cycle to an external combinational multiplier,
// accumulates the products and hands each filter output over valid/ready.
module fir_mac_sched #(
  parameter int TAPS = 4,
  parameter int DW   = 8,
  parameter int ACCW = 18
) (
  input  logic            clk,
  input  logic            rst,
  fir_mac_sched_if.slave  bus
);
  localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [TW-1:0] LAST_TAP = TW'(TAPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  state_t                 state;
  logic [TW-1:0]          tap;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] out_data_r;
  logic                   out_valid_r;
  logic signed [DW-1:0]   coef [TAPS];
  logic signed [DW-1:0]   x    [TAPS];

  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW-1:0] acc_next;

  // Sign-extend the product and form the running sum for this tap
  always_comb begin
    prod_ext = ACCW'(bus.mult_p);
    acc_next = acc + prod_ext;
  end

  // Multiplier operands come from the bank only while accumulating
  always_comb begin
    bus.mult_a = '0;
    bus.mult_b = '0;
    if (state == MAC) begin
      bus.mult_a = coef[tap];
      bus.mult_b = x[tap];
    end
  end

  // Readiness and write acknowledge depend on state only, forced low in reset
  always_comb begin
    bus.in_ready  = (state == IDLE) && !rst;
    bus.coef_ack  = bus.coef_we && (state == IDLE) && !rst;
    bus.out_valid = out_valid_r;
    bus.out_data  = out_data_r;
  end

  // Sequencer: accept a sample, walk the taps, then hold the result until taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tap         <= '0;
      acc         <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        x[k]    <= '0;
        coef[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.coef_we && (int'(bus.coef_addr) < TAPS)) begin
            coef[bus.coef_addr] <= bus.coef_data;
          end
          if (bus.in_valid) begin
            for (int k = TAPS - 1; k > 0; k--) begin
              x[k] <= x[k-1];
            end
            x[0]  <= bus.in_sample;
            acc   <= '0;
            tap   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc_next;
          tap <= tap + TW'(1);
          if (tap == LAST_TAP) begin
            out_data_r  <= acc_next;
            out_valid_r <= 1'b1;
            tap         <= '0;
            state       <= OUT;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
